pipe_controller: RTL
====================

Name: pipe_controller

Overview:
Pipelined successor to the single-cycle Controller for the RISC-V core in each cluster of the multicore cache design. Decodes RV32I in ID and carries control bundles through ID/EX, EX/MEM and MEM/WB stage registers. Generates load-use stalls, branch flushes, optional EX forwarding selects, and a full-pipeline freeze on cache-controller stall.

Parameters:
REG_AW, 5, register address width (rd/rs1/rs2 fields)
FORWARDING, 1, 1 = generate forwarding selects; 0 = resolve all RAW hazards by stalling
ILLEGAL_TRAP, 1, 1 = pulse illegal_o for unknown opcodes; 0 = silently convert them to bubbles

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
instr_id  in  32  instruction in IF/ID register
instr_valid  in  1  instr_id holds a real instruction
br_taken  in  1  EX resolved taken branch or jal/jalr
mem_stall  in  1  cache controller busy; freeze pipeline
stall_if  out  1  hold PC and IF/ID
flush_ifid  out  1  clear IF/ID (load bubble)
alu_op_ex  out  4  ALU operation
sel_A_ex  out  1  0 = rs1, 1 = PC
sel_B_ex  out  1  0 = rs2, 1 = imm
br_type_ex  out  3  branch funct3; 3'b010 = none
fwd_a_ex, fwd_b_ex  out  2  00 = regfile, 01 = EX/MEM, 10 = MEM/WB
rd_en_mem, wr_en_mem  out  1  load / store strobe
mask_mem  out  3  funct3 of load/store
reg_wr_wb  out  1  regfile write enable
wb_sel_wb  out  2  0 = ALU, 1 = mem, 2 = PC+4
rd_wb  out  REG_AW  destination register
illegal_o  out  1  one-cycle pulse on unknown opcode reaching EX

Behaviour:
- Decode (combinational, ID):
  - alu_op: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10.
  - SUB/SRA selected by instr[30] for R-type; SRA only for I-type.
  - Opcodes: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111 (PASS_B), auipc 0010111 (sel_A = 1).
  - Loads and stores use ADD, sel_B = 1. jal/jalr use wb_sel = 2, reg_wr = 1.
  - rs1/rs2 are "used" only for formats that read them.
  - A write with rd = 0 is treated as reg_wr = 0.
- Bubble: all strobes 0, alu_op 0, br_type 3'b010, rd 0, valid 0.
- Reset (reset = 0, async):
  - All stage valids 0 and all registered outputs at bubble values; fwd 00.
  - stall_if = 0, flush_ifid = 0, illegal_o = 0.
  - A reset mid-stall or mid-flush discards all in-flight state.
- Latency: a decoded instruction appears on *_ex 1 cycle after capture, on *_mem after 2, on *_wb after 3.
- Priority per cycle: mem_stall > br_taken > data hazard.
- mem_stall = 1:
  - Every stage register holds; stall_if = 1.
  - br_taken is ignored; the source holds it until mem_stall drops.
- br_taken = 1 (no mem_stall):
  - flush_ifid = 1 and ID/EX loads a bubble.
  - EX/MEM captures the branch normally.
  - Any simultaneous load-use stall is cancelled.
- Load-use (FORWARDING = 1):
  - Condition: EX holds a valid load with rd ≠ 0 matching a used rs of a valid ID instruction.
  - Response: stall_if = 1 for exactly 1 cycle and ID/EX loads a bubble.
- FORWARDING = 0:
  - Stall while any used rs matches a valid rd in EX or MEM.
  - The regfile is write-before-read, so WB matches need no stall.
  - fwd_*_ex tied to 00.
- Forwarding select (registered into ID/EX, evaluated in ID against the next-cycle MEM/WB contents):
  - EX/MEM match has priority over MEM/WB.
  - rs = 0 never forwards.
- Unknown opcode with instr_valid:
  - Enters ID/EX as a bubble.
  - If ILLEGAL_TRAP = 1, illegal_o pulses when it would have been in EX.
- instr_valid = 0: bubble inserted, no hazard evaluation.

Test Plan:
- Reset: hold reset = 0 for 3 cycles, then release → br_type_ex = 3'b010, all strobes 0, stall_if = 0.
- Decode pipeline: sub x3,x1,x2 (0x402081B3) then idle → alu_op_ex = 1 at cycle+1; reg_wr_wb = 1, rd_wb = 3, wb_sel_wb = 0 at cycle+3.
- Load-use: lw x5,4(x6) followed by add x7,x5,x1:
  - stall_if = 1 for exactly 1 cycle, then fwd_a_ex = 10 for the add.
  - With FORWARDING = 0, stall_if = 1 for 2 cycles and fwd_a_ex = 00.
- Forward from EX/MEM: add x3,x1,x2; sub x4,x3,x3 → fwd_a_ex = fwd_b_ex = 01, no stall. With x0 as the destination instead, fwd = 00.
- Branch flush: beq in EX with br_taken = 1 → flush_ifid = 1, next *_ex is a bubble. A simultaneous load-use condition produces no stall.
- Freeze: mem_stall = 1 for 4 cycles during lw → all outputs constant and stall_if = 1. lw reaches WB 3 cycles after mem_stall drops. An unknown opcode 0x0000007F pulses illegal_o for 1 cycle.

Source files
------------

// File: rtl/pipe_controller.sv
// pipe_controller: pipelined RV32I control unit.
//
// Decodes the instruction held in IF/ID and carries the control bundle through
// the ID/EX, EX/MEM and MEM/WB stage registers. Also generates load-use stalls,
// branch flushes, EX operand forwarding selects and a full-pipeline freeze
// while the cache controller is busy.
//
// Ports:
//   clk, reset          core clock, asynchronous active-low reset
//   instr_id            instruction in the IF/ID register
//   instr_valid         instr_id holds a real instruction
//   br_taken            EX resolved a taken branch or jal/jalr
//   mem_stall           cache controller busy: freeze every stage
//   stall_if            hold PC and IF/ID
//   flush_ifid          clear IF/ID
//   *_ex                EX-stage controls (alu_op, operand selects, branch type,
//                       forwarding selects 00 regfile / 01 EX/MEM / 10 MEM/WB)
//   *_mem               MEM-stage load/store strobes and access size
//   *_wb                WB-stage regfile write enable, source select, rd
//   illegal_o           one-cycle pulse when an unknown opcode reaches EX
module pipe_controller #(
  parameter int REG_AW       = 5,
  parameter int FORWARDING   = 1,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_id,
  input  logic              instr_valid,
  input  logic              br_taken,
  input  logic              mem_stall,
  output logic              stall_if,
  output logic              flush_ifid,
  output logic [3:0]        alu_op_ex,
  output logic              sel_A_ex,
  output logic              sel_B_ex,
  output logic [2:0]        br_type_ex,
  output logic [1:0]        fwd_a_ex,
  output logic [1:0]        fwd_b_ex,
  output logic              rd_en_mem,
  output logic              wr_en_mem,
  output logic [2:0]        mask_mem,
  output logic              reg_wr_wb,
  output logic [1:0]        wb_sel_wb,
  output logic [REG_AW-1:0] rd_wb,
  output logic              illegal_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // Full bundle captured into ID/EX; later stages keep only what they consume.
  typedef struct packed {
    logic [3:0]        alu_op;
    logic              sel_a;
    logic              sel_b;
    logic [2:0]        br_type;
    logic              rd_en;
    logic              wr_en;
    logic [2:0]        mask;
    logic              reg_wr;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } ctrl_t;

  typedef struct packed {
    logic              rd_en;
    logic              wr_en;
    logic [2:0]        mask;
    logic              reg_wr;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              reg_wr;
    logic [1:0]        wb_sel;
    logic [REG_AW-1:0] rd;
  } wb_t;

  function automatic ctrl_t bubble_f();
    ctrl_t c;
    c         = '0;
    c.alu_op  = ALU_ADD;
    c.br_type = BR_NONE;
    return c;
  endfunction

  // funct3 -> ALU op; instr[30] picks SUB only for R-type, SRA for both.
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt,
                                        input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // ---------------------------------------------------------------- decode
  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rs1, rs2, rd_f;
  ctrl_t             dec;
  logic              use_rs1, use_rs2, known;

  assign opcode = instr_id[6:0];
  assign f3     = instr_id[14:12];
  assign rd_f   = instr_id[7 +: REG_AW];
  assign rs1    = instr_id[15 +: REG_AW];
  assign rs2    = instr_id[20 +: REG_AW];

  always_comb begin
    dec     = bubble_f();
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    known   = 1'b1;
    case (opcode)
      OP_R: begin
        dec.alu_op = alu_f3(f3, instr_id[30], 1'b1);
        dec.reg_wr = 1'b1;
        dec.rd     = rd_f;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
      end
      OP_I: begin
        dec.alu_op = alu_f3(f3, instr_id[30], 1'b0);
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.rd     = rd_f;
        use_rs1    = 1'b1;
      end
      OP_LOAD: begin
        dec.sel_b  = 1'b1;
        dec.rd_en  = 1'b1;
        dec.mask   = f3;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_MEM;
        dec.rd     = rd_f;
        use_rs1    = 1'b1;
      end
      OP_STORE: begin
        dec.sel_b = 1'b1;
        dec.wr_en = 1'b1;
        dec.mask  = f3;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OP_BRANCH: begin
        // ALU forms the target PC+imm; the comparator reads rs1/rs2.
        dec.sel_a   = 1'b1;
        dec.sel_b   = 1'b1;
        dec.br_type = f3;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_JAL: begin
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.rd     = rd_f;
      end
      OP_JALR: begin
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.wb_sel = WB_PC4;
        dec.rd     = rd_f;
        use_rs1    = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op = ALU_PASS_B;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.rd     = rd_f;
      end
      OP_AUIPC: begin
        dec.sel_a  = 1'b1;
        dec.sel_b  = 1'b1;
        dec.reg_wr = 1'b1;
        dec.rd     = rd_f;
      end
      default: known = 1'b0;
    endcase
    // x0 writes are dropped here so every later rd comparison can rely on
    // reg_wr alone meaning "real, non-zero destination".
    if (!dec.reg_wr || dec.rd == '0) begin
      dec.reg_wr = 1'b0;
      dec.rd     = '0;
    end
  end

  // --------------------------------------------------------- stage registers
  ctrl_t      id_ex;
  logic [1:0] fwd_a_q, fwd_b_q;
  mem_t       ex_mem;
  wb_t        mem_wb;
  logic [3:1] vld_pipe;   // [1] EX, [2] MEM, [3] WB
  logic       illegal_q;

  // ------------------------------------------------------------ hazards
  logic       id_live;
  logic       m_ex1, m_ex2, m_mem1, m_mem2;
  logic       hazard;
  logic [1:0] fwd_a_nx, fwd_b_nx;

  assign id_live = instr_valid && known;

  // A match is against a stage that will write a non-zero rd; rs = 0 is
  // excluded explicitly so x0 never forwards or stalls.
  assign m_ex1  = vld_pipe[1] && id_ex.reg_wr  && use_rs1 && rs1 != '0 && id_ex.rd  == rs1;
  assign m_ex2  = vld_pipe[1] && id_ex.reg_wr  && use_rs2 && rs2 != '0 && id_ex.rd  == rs2;
  assign m_mem1 = vld_pipe[2] && ex_mem.reg_wr && use_rs1 && rs1 != '0 && ex_mem.rd == rs1;
  assign m_mem2 = vld_pipe[2] && ex_mem.reg_wr && use_rs2 && rs2 != '0 && ex_mem.rd == rs2;

  // The select is registered alongside the instruction, so it is decided
  // against what EX/MEM and MEM/WB will hold once this instruction is in EX:
  // today's ID/EX becomes EX/MEM, today's EX/MEM becomes MEM/WB.
  always_comb begin
    hazard   = 1'b0;
    fwd_a_nx = FWD_RF;
    fwd_b_nx = FWD_RF;
    if (FORWARDING != 0) begin
      // Only a load in EX cannot be forwarded in time.
      hazard   = id_live && id_ex.rd_en && (m_ex1 || m_ex2);
      fwd_a_nx = m_ex1 ? FWD_EXM : (m_mem1 ? FWD_MWB : FWD_RF);
      fwd_b_nx = m_ex2 ? FWD_EXM : (m_mem2 ? FWD_MWB : FWD_RF);
    end else begin
      // Write-before-read regfile covers WB, so only EX and MEM stall.
      hazard = id_live && (m_ex1 || m_ex2 || m_mem1 || m_mem2);
    end
  end

  // A taken branch kills the ID instruction anyway, so it cancels a stall.
  logic kill_id;
  assign kill_id = br_taken || hazard || !id_live;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex     <= bubble_f();
      fwd_a_q   <= FWD_RF;
      fwd_b_q   <= FWD_RF;
      ex_mem    <= '0;
      mem_wb    <= '0;
      vld_pipe  <= '0;
      illegal_q <= 1'b0;
    end else if (!mem_stall) begin
      id_ex     <= kill_id ? bubble_f() : dec;
      fwd_a_q   <= kill_id ? FWD_RF : fwd_a_nx;
      fwd_b_q   <= kill_id ? FWD_RF : fwd_b_nx;
      ex_mem    <= '{rd_en:  id_ex.rd_en,  wr_en:  id_ex.wr_en, mask: id_ex.mask,
                     reg_wr: id_ex.reg_wr, wb_sel: id_ex.wb_sel, rd: id_ex.rd};
      mem_wb    <= '{reg_wr: ex_mem.reg_wr, wb_sel: ex_mem.wb_sel, rd: ex_mem.rd};
      vld_pipe  <= {vld_pipe[2:1], !kill_id};
      // Wrong-path (flushed) unknown opcodes do not trap.
      illegal_q <= (ILLEGAL_TRAP != 0) && instr_valid && !known && !br_taken;
    end else begin
      // Frozen: the pulse must not stretch across the stall.
      illegal_q <= 1'b0;
    end
  end

  // ------------------------------------------------------------ outputs
  assign stall_if   = reset && (mem_stall || (hazard && !br_taken));
  assign flush_ifid = reset && !mem_stall && br_taken;

  assign alu_op_ex  = id_ex.alu_op;
  assign sel_A_ex   = id_ex.sel_a;
  assign sel_B_ex   = id_ex.sel_b;
  assign br_type_ex = id_ex.br_type;
  assign fwd_a_ex   = fwd_a_q;
  assign fwd_b_ex   = fwd_b_q;
  assign rd_en_mem  = ex_mem.rd_en;
  assign wr_en_mem  = ex_mem.wr_en;
  assign mask_mem   = ex_mem.mask;
  assign reg_wr_wb  = mem_wb.reg_wr;
  assign wb_sel_wb  = mem_wb.wb_sel;
  assign rd_wb      = mem_wb.rd;
  assign illegal_o  = illegal_q;

  // Immediate bits and the WB valid are not consumed by control.
  logic unused_bits;
  assign unused_bits = ^{instr_id, vld_pipe[3]};

endmodule
